// File: rtl/axi_lite_reg_responder.sv
// axi_lite_reg_responder: AXI4-Lite slave exposing an ID, scratch, cycle counter, control and general registers.
// Define AXI_LITE_REG_WSTRB_EN to honour WSTRB byte lanes; otherwise every write stores the full word.
module axi_lite_reg_responder #(
    parameter logic [31:0] C_BASEADDR = 32'h7d41_0000,
    parameter logic [31:0] C_HIGHADDR = 32'h7d41_ffff,
    parameter int          C_NUM_REGS = 16,
    parameter logic [31:0] C_ID       = 32'h4e46_0001
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESET,
    input  logic [31:0]             S_AXI_AWADDR,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [31:0]             S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [31:0]             S_AXI_ARADDR,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [31:0]             S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY,
    output logic [32*C_NUM_REGS-1:0] ctrl_regs
);
    localparam int IW = $clog2(C_NUM_REGS);
    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic alive, aw_hs, w_hs, ar_hs, wr_fire, wr_ok, clr;
    logic [31:0] aw_q, w_q, wr_addr, wr_data, wr_mask, cnt;
    logic [1:0] wr_resp;
    logic [IW-1:0] wr_idx, rd_idx;

    function automatic logic hit(input logic [31:0] a);
        return a >= C_BASEADDR && a <= C_HIGHADDR && ((a - C_BASEADDR) >> 2) < 32'(C_NUM_REGS);
    endfunction

    function automatic logic [IW-1:0] index(input logic [31:0] a);
        return IW'((a - C_BASEADDR) >> 2);
    endfunction

    always_comb begin
        S_AXI_AWREADY = alive && (w_state == W_IDLE || w_state == W_HAVE_DATA);
        S_AXI_WREADY  = alive && (w_state == W_IDLE || w_state == W_HAVE_ADDR);
        S_AXI_BVALID  = w_state == W_RESP;
        aw_hs   = S_AXI_AWVALID && S_AXI_AWREADY;
        w_hs    = S_AXI_WVALID && S_AXI_WREADY;
        wr_addr = aw_hs ? S_AXI_AWADDR : aw_q;
        wr_data = w_hs ? S_AXI_WDATA : w_q;
        wr_fire = (aw_hs || w_state == W_HAVE_ADDR) && (w_hs || w_state == W_HAVE_DATA);
        wr_idx  = index(wr_addr);
        wr_resp = !hit(wr_addr) ? 2'b11 : (wr_idx == '0 || wr_idx == IW'(2)) ? 2'b10 : 2'b00;
        wr_ok   = wr_fire && wr_resp == 2'b00;
        clr     = wr_ok && wr_idx == IW'(3) && wr_data[0] && wr_mask[0];
        w_next  = wr_fire ? W_RESP :
                  w_state == W_RESP ? (S_AXI_BREADY ? W_IDLE : W_RESP) :
                  aw_hs ? W_HAVE_ADDR : w_hs ? W_HAVE_DATA : w_state;
    end

    always_comb begin
        S_AXI_ARREADY = alive && r_state == R_IDLE;
        S_AXI_RVALID  = r_state == R_DATA;
        ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
        rd_idx = index(S_AXI_ARADDR);
        r_next = ar_hs ? R_DATA : (S_AXI_RVALID && S_AXI_RREADY) ? R_IDLE : r_state;
    end

`ifdef AXI_LITE_REG_WSTRB_EN
    logic [3:0] ws_q, wr_strb;
    assign wr_strb = w_hs ? S_AXI_WSTRB : ws_q;
    assign wr_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
        if (S_AXI_ARESET) ws_q <= '0;
        else if (w_hs) ws_q <= S_AXI_WSTRB;
`else
    logic unused_wstrb;
    assign unused_wstrb = ^S_AXI_WSTRB;
    assign wr_mask = '1;
`endif

    // alive holds the READY outputs low until the first edge after reset release
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
        if (S_AXI_ARESET) begin
            alive       <= 1'b0;
            w_state     <= W_IDLE;
            r_state     <= R_IDLE;
            aw_q        <= '0;
            w_q         <= '0;
            S_AXI_BRESP <= 2'b00;
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= 2'b00;
            cnt         <= '0;
        end else begin
            alive   <= 1'b1;
            w_state <= w_next;
            r_state <= r_next;
            if (aw_hs) aw_q <= S_AXI_AWADDR;
            if (w_hs) w_q <= S_AXI_WDATA;
            if (wr_fire) S_AXI_BRESP <= wr_resp;
            if (ar_hs) begin
                S_AXI_RDATA <= hit(S_AXI_ARADDR) ? ctrl_regs[32*rd_idx +: 32] : '0;
                S_AXI_RRESP <= hit(S_AXI_ARADDR) ? 2'b00 : 2'b11;
            end
            cnt <= clr ? '0 : cnt + 1'b1;
        end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_reg
        if (g == 0) begin : g_id
            assign ctrl_regs[32*g +: 32] = C_ID;
        end else if (g == 2) begin : g_cnt
            assign ctrl_regs[32*g +: 32] = cnt;
        end else begin : g_rw
            logic [31:0] q;
            // the control register's clear bit is a strobe, so it never stays set
            always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
                if (S_AXI_ARESET) q <= '0;
                else if (wr_ok && wr_idx == IW'(g)) q <= ((q & ~wr_mask) | (wr_data & wr_mask)) & ~(g == 3 ? 32'h1 : 32'h0);
            assign ctrl_regs[32*g +: 32] = q;
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// tb_axi_lite_reg_responder: randomized AXI4-Lite traffic checked against a register-map model.
module tb_axi_lite_reg_responder;
    localparam logic [31:0] BASE = 32'h7d41_0000;
    localparam logic [31:0] HIGH = 32'h7d41_ffff;
    localparam logic [31:0] ID   = 32'h4e46_0001;
    localparam int NR = 16;

    logic clk = 0, rst = 1;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0;
    logic [3:0] wstrb = 0;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;
    logic [32*NR-1:0] ctrl_regs;

    int tests = 0, fails = 0, cyc = 0, base_edge = 0;
    logic [31:0] m [NR];

    axi_lite_reg_responder dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ctrl_regs(ctrl_regs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [1:0] m_resp(input logic [31:0] a, input bit wr);
        int i;
        if (a < BASE || a > HIGH || (a - BASE) / 4 >= NR) return 2'b11;
        i = int'((a - BASE) / 4);
        if (wr && (i == 0 || i == 2)) return 2'b10;
        return 2'b00;
    endfunction

    // counter value after edge number cyc is the number of edges since the last clear
    function automatic logic [31:0] m_cnt();
        return rst ? 32'h0 : 32'(cyc - base_edge);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int i;
        if (m_resp(a, 0) != 2'b00) return 32'h0;
        i = int'((a - BASE) / 4);
        return i == 0 ? ID : i == 2 ? m_cnt() : m[i];
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int i;
        logic [31:0] mk;
        if (m_resp(a, 1) != 2'b00) return;
        i = int'((a - BASE) / 4);
`ifdef AXI_LITE_REG_WSTRB_EN
        mk = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
`else
        mk = 32'hffff_ffff;
`endif
        if (i == 3 && d[0] && mk[0]) base_edge = cyc;
        m[i] = (m[i] & ~mk) | (d & mk);
        if (i == 3) m[i][0] = 1'b0;
    endfunction

    function automatic logic [32*NR-1:0] exp_ctrl();
        logic [32*NR-1:0] v;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = i == 0 ? ID : i == 2 ? m_cnt() : m[i];
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0: return BASE + $urandom_range(NR, 16383) * 4 + $urandom_range(0, 3);
            1: return $urandom_range(0, 1) ? BASE - 1 - $urandom_range(0, 1000) : HIGH + 1 + $urandom_range(0, 1000);
            default: return BASE + $urandom_range(0, NR - 1) * 4 + $urandom_range(0, 3);
        endcase
    endfunction

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input bit hold_b, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_go, w_go;
        int c = 0;
        while (!(aw_done && w_done) && c < 40) begin
            @(negedge clk);
            awaddr = a; wdata = d; wstrb = s;
            awvalid = !aw_done && c >= aw_dly;
            wvalid  = !w_done && c >= w_dly;
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(posedge clk);
            aw_done |= aw_go;
            w_done  |= w_go;
            c++;
        end
        @(negedge clk);
        awvalid = 0; wvalid = 0;
        if (aw_done && w_done) m_write(a, d, s);
        resp = bresp;
        tests++;
        if (!(aw_done && w_done) || bvalid !== 1'b1) begin
            fails++;
            $display("FAIL wr_bvalid addr=%h got bvalid=%b want 1", a, bvalid);
        end
        tests++;
        if (bresp !== m_resp(a, 1)) begin
            fails++;
            $display("FAIL wr_bresp addr=%h got %b want %b", a, bresp, m_resp(a, 1));
        end
        tests++;
        if (ctrl_regs !== exp_ctrl()) begin
            fails++;
            $display("FAIL wr_ctrl_regs addr=%h got %h want %h", a, ctrl_regs, exp_ctrl());
        end
        if (!hold_b) begin
            bready = 1;
            @(posedge clk);
            @(negedge clk);
            bready = 0;
        end
    endtask

    task automatic axi_read(input logic [31:0] a, input bit hold_r, output logic [31:0] d, output logic [1:0] r);
        logic [31:0] ed = 0;
        logic [1:0] er = 0;
        bit go = 0;
        int c = 0;
        while (!go && c < 40) begin
            @(negedge clk);
            araddr = a; arvalid = 1;
            go = arready;
            ed = m_read(a);
            er = m_resp(a, 0);
            @(posedge clk);
            c++;
        end
        @(negedge clk);
        arvalid = 0;
        d = rdata; r = rresp;
        tests++;
        if (!go || rvalid !== 1'b1) begin
            fails++;
            $display("FAIL rd_rvalid addr=%h got rvalid=%b want 1", a, rvalid);
        end
        tests++;
        if (rdata !== ed || rresp !== er) begin
            fails++;
            $display("FAIL rd_data addr=%h got %h/%b want %h/%b", a, rdata, rresp, ed, er);
        end
        if (!hold_r) begin
            rready = 1;
            @(posedge clk);
            @(negedge clk);
            rready = 0;
        end
    endtask

    task automatic release_reset;
        repeat (2) @(negedge clk);
        rst = 0;
        base_edge = cyc;
        @(negedge clk);
        tests++;
        if ({awready, wready, arready} !== 3'b111) begin
            fails++;
            $display("FAIL ready_after_reset got %b want 111", {awready, wready, arready});
        end
    endtask

    task automatic test_reset;
        rst = 1;
        for (int i = 0; i < NR; i++) m[i] = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            fails++;
            $display("FAIL reset_handshake got %b want 00000", {awready, wready, arready, bvalid, rvalid});
        end
        tests++;
        if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_resp got %b/%b/%h want 00/00/0", bresp, rresp, rdata);
        end
        tests++;
        if (ctrl_regs !== exp_ctrl()) begin
            fails++;
            $display("FAIL reset_ctrl_regs got %h want %h", ctrl_regs, exp_ctrl());
        end
        release_reset;
    endtask

    task automatic test_id_read;
        logic [31:0] d;
        logic [1:0] r;
        axi_read(BASE, 0, d, r);
        tests++;
        if (d !== ID || r !== 2'b00) begin
            fails++;
            $display("FAIL id_read got %h/%b want %h/00", d, r, ID);
        end
    endtask

    task automatic test_split_write;
        logic [31:0] d;
        logic [1:0] r, br;
        axi_write(BASE + 4, 32'hdeadbeef, 4'hf, 0, 2, 0, br);
        axi_read(BASE + 4, 0, d, r);
        tests++;
        if (br !== 2'b00 || d !== 32'hdeadbeef || ctrl_regs[63:32] !== 32'hdeadbeef) begin
            fails++;
            $display("FAIL split_write got bresp=%b rd=%h reg1=%h want 00/deadbeef/deadbeef", br, d, ctrl_regs[63:32]);
        end
        axi_write(BASE + 4, 32'h0000_1234, 4'hf, 2, 0, 0, br);
    endtask

    task automatic test_errors;
        logic [31:0] d;
        logic [1:0] r, br;
        axi_write(BASE, 32'h1111_2222, 4'hf, 0, 0, 0, br);
        tests++;
        if (br !== 2'b10 || ctrl_regs[31:0] !== ID) begin
            fails++;
            $display("FAIL write_ro got %b/%h want 10/%h", br, ctrl_regs[31:0], ID);
        end
        axi_read(BASE + 32'h1_0000, 0, d, r);
        tests++;
        if (r !== 2'b11 || d !== 32'h0) begin
            fails++;
            $display("FAIL read_outside got %b/%h want 11/0", r, d);
        end
        axi_write(BASE + 8, 32'h5555_5555, 4'hf, 1, 0, 0, br);
        axi_write(BASE + 32'h40, 32'h5555_5555, 4'hf, 0, 0, 0, br);
        axi_read(BASE + 32'h40, 0, d, r);
        axi_read(BASE - 4, 0, d, r);
    endtask

    task automatic test_counter_clear;
        logic [31:0] d;
        logic [1:0] r, br;
        axi_write(BASE + 12, 32'h1, 4'hf, 0, 0, 0, br);
        axi_read(BASE + 8, 0, d, r);
        tests++;
        if (d !== 32'd2) begin
            fails++;
            $display("FAIL counter_clear got %0d want 2", d);
        end
        axi_read(BASE + 12, 0, d, r);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("FAIL ctrl_selfclear got %h want 0", d);
        end
    endtask

    task automatic test_wstrb;
        logic [31:0] d, exp;
        logic [1:0] r, br;
`ifdef AXI_LITE_REG_WSTRB_EN
        exp = 32'h11bb33dd;
`else
        exp = 32'haabbccdd;
`endif
        axi_write(BASE + 20, 32'h11223344, 4'hf, 0, 0, 0, br);
        axi_write(BASE + 20, 32'haabbccdd, 4'b0101, 0, 1, 0, br);
        axi_read(BASE + 20, 0, d, r);
        tests++;
        if (d !== exp || ctrl_regs[191:160] !== exp) begin
            fails++;
            $display("FAIL wstrb got %h/%h want %h", d, ctrl_regs[191:160], exp);
        end
        axi_write(BASE + 20, 32'h0, 4'b0000, 0, 0, 0, br);
        axi_read(BASE + 20, 0, d, r);
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        logic [1:0] r, br;
        axi_write(BASE + 4, 32'h1234_5678, 4'hf, 0, 0, 0, br);
        fork
            axi_write(BASE + 4, 32'h0bad_f00d, 4'hf, 0, 0, 0, br);
            axi_read(BASE + 4, 0, d, r);
        join
        tests++;
        if (d !== 32'h1234_5678 || ctrl_regs[63:32] !== 32'h0bad_f00d) begin
            fails++;
            $display("FAIL same_cycle_rw got rd=%h reg1=%h want 12345678/0badf00d", d, ctrl_regs[63:32]);
        end
        fork
            axi_write(BASE + 12, 32'h1, 4'hf, 0, 0, 0, br);
            axi_read(BASE + 8, 0, d, r);
        join
        tests++;
        if (d === 32'h0) begin
            fails++;
            $display("FAIL clear_read_precount got %h want nonzero pre-clear count", d);
        end
        axi_read(BASE + 8, 0, d, r);
    endtask

    task automatic test_random;
        logic [31:0] a, d;
        logic [1:0] r, br;
        for (int k = 0; k < 40; k++) begin
            a = rand_addr();
            axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2), 0, br);
            axi_read(a, 0, d, r);
            axi_read(rand_addr(), 0, d, r);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] d;
        logic [1:0] r, br;
        axi_write(BASE + 24, 32'h5a5a_5a5a, 4'hf, 1, 0, 1, br);
        axi_read(BASE + 24, 1, d, r);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            tests++;
            if (bvalid !== 1'b1 || rvalid !== 1'b1 || rdata !== d || rresp !== r || bresp !== br ||
                {awready, wready, arready} !== 3'b000) begin
                fails++;
                $display("FAIL hold cycle=%0d got bv=%b rv=%b rd=%h rdy=%b want 1/1/%h/000",
                         k, bvalid, rvalid, rdata, {awready, wready, arready}, d);
            end
        end
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < NR; i++) m[i] = 0;
        #1;
        tests++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || bresp !== 2'b00 || rresp !== 2'b00 ||
            rdata !== 32'h0 || ctrl_regs !== exp_ctrl()) begin
            fails++;
            $display("FAIL reset_mid_hold got hs=%b bresp=%b rresp=%b rdata=%h", {awready, wready, arready, bvalid, rvalid},
                     bresp, rresp, rdata);
        end
        release_reset;
        axi_read(BASE + 24, 0, d, r);
    endtask

    initial begin
        test_reset;
        test_id_read;
        test_split_write;
        test_errors;
        test_counter_clear;
        test_wstrb;
        test_back_to_back;
        test_random;
        test_backpressure;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
